// File: rtl/frame_diff_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_diff_pkg                                                       |
// | Shared widths, arming states and overlay constants for motion path.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
package frame_diff_pkg;

  localparam int PIX_W = 8;
  localparam int CNT_W = 19;

  typedef enum logic [1:0] {
    WAIT_FRAME  = 2'd0,
    FIRST_FRAME = 2'd1,
    ACTIVE      = 2'd2
  } arm_state_t;

  // Overlay colours used by the rectangle-marking stages downstream.
  localparam logic [23:0]      c_red_mark_rgb = 24'hFF0000;
  localparam logic [23:0]      c_black_rgb    = 24'h000000;
  localparam logic [PIX_W-1:0] c_mask_on_y    = 8'hFF;
  localparam logic [PIX_W-1:0] c_mask_off_y   = 8'h00;

  // Magnitude of a 9-bit two's-complement pixel difference; 255 is the largest.
  function automatic logic [PIX_W-1:0] abs_diff(input logic [PIX_W:0] d);
    logic [PIX_W:0] w_neg;
    w_neg = ~d + 1'b1;
    return d[PIX_W] ? w_neg[PIX_W-1:0] : d[PIX_W-1:0];
  endfunction

endpackage
`default_nettype wire

// File: rtl/sync_delay_line.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | sync_delay_line                                                      |
// | Fixed-depth shift register for aligning frame sync strobes.          |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module sync_delay_line #(
  parameter int WIDTH = 1,
  parameter int DEPTH = 1
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
);

  logic [WIDTH*DEPTH-1:0] r_shift;

  generate
    if (DEPTH == 1) begin : g_single
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_shift <= '0;
        else        r_shift <= din;
      end
    end else begin : g_chain
      always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) r_shift <= '0;
        else        r_shift <= {r_shift[WIDTH*(DEPTH-1)-1:0], din};
      end
    end
  endgenerate

  assign dout = r_shift[WIDTH*DEPTH-1 -: WIDTH];

endmodule
`default_nettype wire

// File: rtl/frame_diff_binarize.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | frame_diff_binarize                                                  |
// | |cur - prev| > threshold motion mask with per-frame pixel count.     |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module frame_diff_binarize
  import frame_diff_pkg::*;
#(
  parameter logic [10:0]      IMG_WIDTH         = 11'd640,
  parameter logic [10:0]      IMG_HEIGHT        = 11'd480,
  parameter logic [CNT_W-1:0] MIN_MOTION_PIXELS = 19'd200,
  parameter int               PIPE_DEPTH        = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             per_frame_vsync,
  input  logic             per_frame_href,
  input  logic             per_frame_clken,
  input  logic [PIX_W-1:0] per_img_Y,
  input  logic [PIX_W-1:0] prev_img_Y,
  input  logic [PIX_W-1:0] diff_threshold,
  output logic             post_frame_vsync,
  output logic             post_frame_href,
  output logic             post_frame_clken,
  output logic             post_img_Bit,
  output logic [CNT_W-1:0] motion_pixel_cnt,
  output logic             motion_flag
);

  localparam int              c_frame_pixels = int'(IMG_WIDTH) * int'(IMG_HEIGHT);
  localparam logic [CNT_W-1:0] c_cnt_one     = 1;

  generate
    if (PIPE_DEPTH != 3 || c_frame_pixels > (1 << CNT_W) - 1) begin : g_param_check
      $error("frame_diff_binarize: PIPE_DEPTH must be 3 and a frame must fit the counter");
    end
  endgenerate

  // ---------------- input-side frame tracking ----------------
  logic       r_vsync_d;
  logic       r_primed;
  logic       w_vs_rise;
  logic       w_vs_fall;
  arm_state_t r_state;
  logic [PIX_W-1:0] r_thr;

  // r_primed blocks a false rising edge when reset releases mid-frame.
  assign w_vs_rise = per_frame_vsync & ~r_vsync_d & r_primed;
  assign w_vs_fall = ~per_frame_vsync & r_vsync_d & r_primed;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_vsync_d <= 1'b0;
      r_primed  <= 1'b0;
      r_thr     <= '0;
      r_state   <= WAIT_FRAME;
    end else begin
      r_vsync_d <= per_frame_vsync;
      r_primed  <= 1'b1;
      if (w_vs_rise) r_thr <= diff_threshold;
      case (r_state)
        WAIT_FRAME:  if (w_vs_rise) r_state <= FIRST_FRAME;
        FIRST_FRAME: if (w_vs_fall) r_state <= ACTIVE;
        ACTIVE:      r_state <= ACTIVE;
        default:     r_state <= WAIT_FRAME;
      endcase
    end
  end

  // ---------------- pixel pipeline ----------------
  logic [PIX_W:0]   r_diff;
  logic [PIX_W-1:0] r_abs;
  logic             r_arm1;
  logic             r_arm2;
  logic             r_hit;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_diff <= '0;
      r_arm1 <= 1'b0;
      r_abs  <= '0;
      r_arm2 <= 1'b0;
      r_hit  <= 1'b0;
    end else begin
      r_diff <= {1'b0, per_img_Y} - {1'b0, prev_img_Y};
      r_arm1 <= (r_state == ACTIVE);
      r_abs  <= abs_diff(r_diff);
      r_arm2 <= r_arm1;
      r_hit  <= (r_abs > r_thr) & r_arm2;
    end
  end

  logic [2:0] w_post_sync;

  sync_delay_line #(
    .WIDTH (3),
    .DEPTH (PIPE_DEPTH)
  ) u_sync_delay (
    .clk   (clk),
    .rst_n (rst_n),
    .din   ({per_frame_vsync, per_frame_href, per_frame_clken}),
    .dout  (w_post_sync)
  );

  assign post_frame_vsync = w_post_sync[2];
  assign post_frame_href  = w_post_sync[1];
  assign post_frame_clken = w_post_sync[0];
  assign post_img_Bit     = r_hit & post_frame_href & post_frame_clken;

  // ---------------- output-side motion counter ----------------
  logic             r_post_vs_d;
  logic [CNT_W-1:0] r_cnt;
  logic             w_post_rise;
  logic             w_post_fall;

  assign w_post_rise = post_frame_vsync & ~r_post_vs_d;
  assign w_post_fall = ~post_frame_vsync & r_post_vs_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_post_vs_d      <= 1'b0;
      r_cnt            <= '0;
      motion_pixel_cnt <= '0;
      motion_flag      <= 1'b0;
    end else begin
      r_post_vs_d <= post_frame_vsync;
      if (w_post_rise)
        r_cnt <= '0;
      else if (post_img_Bit && r_cnt != '1)
        r_cnt <= r_cnt + c_cnt_one;
      if (w_post_fall) begin
        motion_pixel_cnt <= r_cnt;
        motion_flag      <= (r_cnt > MIN_MOTION_PIXELS);
      end
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_frame_diff_binarize.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | tb_frame_diff_binarize                                               |
// | Self-checking bench: frame tables, corner sequences, random frames.  |
// | Revision: 1.0                                                        |
// +----------------------------------------------------------------------+
module tb_frame_diff_binarize;

  localparam int c_min_motion = 200;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        per_frame_vsync = 1'b0;
  logic        per_frame_href = 1'b0;
  logic        per_frame_clken = 1'b0;
  logic [7:0]  per_img_Y = 8'd0;
  logic [7:0]  prev_img_Y = 8'd0;
  logic [7:0]  diff_threshold = 8'd10;
  logic        post_frame_vsync;
  logic        post_frame_href;
  logic        post_frame_clken;
  logic        post_img_Bit;
  logic [18:0] motion_pixel_cnt;
  logic        motion_flag;

  frame_diff_binarize #(
    .IMG_WIDTH         (11'd640),
    .IMG_HEIGHT        (11'd480),
    .MIN_MOTION_PIXELS (19'd200),
    .PIPE_DEPTH        (3)
  ) dut (
    .clk              (clk),
    .rst_n            (rst_n),
    .per_frame_vsync  (per_frame_vsync),
    .per_frame_href   (per_frame_href),
    .per_frame_clken  (per_frame_clken),
    .per_img_Y        (per_img_Y),
    .prev_img_Y       (prev_img_Y),
    .diff_threshold   (diff_threshold),
    .post_frame_vsync (post_frame_vsync),
    .post_frame_href  (post_frame_href),
    .post_frame_clken (post_frame_clken),
    .post_img_Bit     (post_img_Bit),
    .motion_pixel_cnt (motion_pixel_cnt),
    .motion_flag      (motion_flag)
  );

  always #5 clk = ~clk;

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int n_checks = 0;
  int n_fail   = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Reference model: frame-level view of arming, threshold latching and counting.
  typedef struct {
    logic vs, hs, ce, b;
  } exp_t;

  exp_t q[$];
  bit   m_primed, m_prev_vs, m_first_open, m_armed, m_post_prev_vs;
  int   m_thr, m_acc, m_cnt;
  bit   m_flag;

  logic [7:0] cur_img [256];
  logic [7:0] prev_img[256];

  function automatic logic [7:0] rnd8();
    return 8'($urandom_range(0, 255));
  endfunction

  function automatic int absdiff(input logic [7:0] a, input logic [7:0] b);
    int d;
    d = int'(a) - int'(b);
    return (d < 0) ? -d : d;
  endfunction

  task automatic model_reset();
    exp_t z;
    z = '{vs: 1'b0, hs: 1'b0, ce: 1'b0, b: 1'b0};
    q.delete();
    q.push_back(z);
    q.push_back(z);
    m_primed = 0; m_prev_vs = 0; m_first_open = 0; m_armed = 0;
    m_post_prev_vs = 0; m_thr = 0; m_acc = 0; m_cnt = 0; m_flag = 0;
  endtask

  task automatic step(input logic vs, input logic hs, input logic ce,
                      input logic [7:0] cur, input logic [7:0] prv);
    exp_t e;
    exp_t o;
    per_frame_vsync = vs;
    per_frame_href  = hs;
    per_frame_clken = ce;
    per_img_Y       = cur;
    prev_img_Y      = prv;
    @(posedge clk);
    if (m_primed && vs && !m_prev_vs) begin
      m_thr = int'(diff_threshold);
      if (!m_armed) m_first_open = 1;
    end
    e.vs = vs; e.hs = hs; e.ce = ce;
    e.b  = m_armed && hs && ce && (absdiff(cur, prv) > m_thr);
    if (m_primed && !vs && m_prev_vs && m_first_open) begin
      m_armed = 1;
      m_first_open = 0;
    end
    m_prev_vs = vs;
    m_primed  = 1;
    q.push_back(e);
    @(negedge clk);
    o = q.pop_front();
    check("stream", {28'd0, post_frame_vsync, post_frame_href, post_frame_clken, post_img_Bit},
          {28'd0, o.vs, o.hs, o.ce, o.b});
    check("count", {12'd0, motion_flag, motion_pixel_cnt}, {12'd0, m_flag, 19'(m_cnt)});
    if (!o.vs && m_post_prev_vs) begin
      m_cnt  = m_acc;
      m_flag = (m_acc > c_min_motion);
    end
    if (o.vs && !m_post_prev_vs) m_acc = 0;
    else if (o.b && m_acc < 524287) m_acc++;
    m_post_prev_vs = o.vs;
  endtask

  task automatic do_reset();
    #2 rst_n = 1'b0;
    #1 check("async_reset", {12'd0, post_frame_vsync, post_frame_href, post_frame_clken,
                             post_img_Bit, motion_flag, motion_pixel_cnt[14:0]}, 32'd0);
    check("async_reset_cnt", {13'd0, motion_pixel_cnt}, 32'd0);
    @(negedge clk);
    rst_n = 1'b1;
    model_reset();
  endtask

  task automatic frame(input int w, input int h, input bit gaps, input int chg_idx,
                       input logic [7:0] thr2, input int rst_idx);
    int idx;
    idx = 0;
    repeat (4) step(1'b0, 1'b0, 1'b0, rnd8(), rnd8());
    repeat (2) step(1'b1, 1'b0, 1'b0, rnd8(), rnd8());
    for (int y = 0; y < h; y++) begin
      for (int x = 0; x < w; x++) begin
        if (gaps) while ($urandom_range(0, 3) == 0) step(1'b1, 1'b1, 1'b0, rnd8(), rnd8());
        if (idx == chg_idx) diff_threshold = thr2;
        if (idx == rst_idx) do_reset();
        step(1'b1, 1'b1, 1'b1, cur_img[idx], prev_img[idx]);
        idx++;
      end
      repeat (3) step(1'b1, 1'b0, 1'b0, rnd8(), rnd8());
    end
    repeat (2) step(1'b1, 1'b0, 1'b0, rnd8(), rnd8());
    repeat (6) step(1'b0, 1'b0, 1'b0, rnd8(), rnd8());
  endtask

  task automatic fill(input logic [7:0] c, input logic [7:0] p);
    for (int i = 0; i < 256; i++) begin
      cur_img[i]  = c;
      prev_img[i] = p;
    end
  endtask

  typedef struct {
    logic [7:0] cur, prv, thr;
    int         cnt;
    bit         flag;
  } vec_t;

  vec_t vecs[8];

  initial begin
    int exp_cnt;
    vecs[0] = '{cur: 8'd100, prv: 8'd100, thr: 8'd10,  cnt: 0,  flag: 1'b0};
    vecs[1] = '{cur: 8'd100, prv: 8'd100, thr: 8'd10,  cnt: 0,  flag: 1'b0};
    vecs[2] = '{cur: 8'd100, prv: 8'd100, thr: 8'd10,  cnt: 0,  flag: 1'b0};
    vecs[3] = '{cur: 8'd120, prv: 8'd100, thr: 8'd20,  cnt: 0,  flag: 1'b0};
    vecs[4] = '{cur: 8'd120, prv: 8'd100, thr: 8'd19,  cnt: 32, flag: 1'b0};
    vecs[5] = '{cur: 8'd0,   prv: 8'd255, thr: 8'd254, cnt: 32, flag: 1'b0};
    vecs[6] = '{cur: 8'd255, prv: 8'd0,   thr: 8'd255, cnt: 0,  flag: 1'b0};
    vecs[7] = '{cur: 8'd10,  prv: 8'd60,  thr: 8'd49,  cnt: 32, flag: 1'b0};

    repeat (3) @(negedge clk);
    check("reset_outputs", {12'd0, post_frame_vsync, post_frame_href, post_frame_clken,
                            post_img_Bit, motion_flag, motion_pixel_cnt[14:0]}, 32'd0);
    rst_n = 1'b1;
    model_reset();

    // Uniform 8x4 frames; the first after reset must stay masked.
    for (int i = 0; i < 8; i++) begin
      fill(vecs[i].cur, vecs[i].prv);
      diff_threshold = vecs[i].thr;
      frame(8, 4, 1'b0, -1, 8'd0, -1);
      check($sformatf("table%0d_cnt", i), {13'd0, motion_pixel_cnt}, 32'(vecs[i].cnt));
      check($sformatf("table%0d_flag", i), {31'd0, motion_flag}, {31'd0, vecs[i].flag});
    end

    // Lone pixel (3,2) at maximum difference.
    fill(8'd77, 8'd77);
    cur_img[19] = 8'd0;
    prev_img[19] = 8'd255;
    diff_threshold = 8'd254;
    frame(8, 4, 1'b0, -1, 8'd0, -1);
    check("single_pixel_cnt", {13'd0, motion_pixel_cnt}, 32'd1);

    // Threshold changed mid-frame applies only from the next frame.
    fill(8'd150, 8'd100);
    diff_threshold = 8'd200;
    frame(8, 4, 1'b0, 10, 8'd5, -1);
    check("thr_midframe_cnt", {13'd0, motion_pixel_cnt}, 32'd0);
    frame(8, 4, 1'b0, -1, 8'd0, -1);
    check("thr_nextframe_cnt", {13'd0, motion_pixel_cnt}, 32'd32);

    // Motion flag boundary around 200 pixels.
    diff_threshold = 8'd10;
    for (int k = 0; k < 3; k++) begin
      int n;
      n = (k == 0) ? 256 : (k == 1) ? 200 : 201;
      for (int i = 0; i < 256; i++) begin
        cur_img[i]  = (i < n) ? 8'd200 : 8'd100;
        prev_img[i] = 8'd100;
      end
      frame(16, 16, 1'b0, -1, 8'd0, -1);
      check($sformatf("flag%0d_cnt", n), {13'd0, motion_pixel_cnt}, 32'(n));
      check($sformatf("flag%0d_flag", n), {31'd0, motion_flag}, {31'd0, n > c_min_motion});
    end

    // Reset mid-line of an armed frame: re-arm takes one full frame.
    fill(8'd200, 8'd100);
    frame(8, 4, 1'b0, -1, 8'd0, 12);
    check("after_reset_partial_cnt", {13'd0, motion_pixel_cnt}, 32'd0);
    frame(8, 4, 1'b0, -1, 8'd0, -1);
    check("after_reset_first_cnt", {13'd0, motion_pixel_cnt}, 32'd0);
    frame(8, 4, 1'b0, -1, 8'd0, -1);
    check("after_reset_normal_cnt", {13'd0, motion_pixel_cnt}, 32'd32);

    // Random frames with clken gaps.
    for (int f = 0; f < 6; f++) begin
      diff_threshold = 8'($urandom_range(0, 80));
      exp_cnt = 0;
      for (int i = 0; i < 60; i++) begin
        cur_img[i]  = rnd8();
        prev_img[i] = ($urandom_range(0, 1) == 1) ? rnd8()
                      : 8'(int'(cur_img[i]) ^ $urandom_range(0, 127));
        if (absdiff(cur_img[i], prev_img[i]) > int'(diff_threshold)) exp_cnt++;
      end
      frame(10, 6, 1'b1, -1, 8'd0, -1);
      check($sformatf("random%0d_cnt", f), {13'd0, motion_pixel_cnt}, 32'(exp_cnt));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
`default_nettype wire
